// File: rtl/mul_113_recon.sv
// Sequential X = Q*113 + R reconstruction, radix-128 digits with a carry chain.
// Optional macro MUL_113_RECON_REM_CHECK_EN adds the R >= 113 error flag.
module mul_113_recon #(
  parameter int unsigned DIGITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [53:0] Q,
  input  logic [6:0]  R,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [59:0] X,
  output logic        ovf,
  output logic        err
);

  localparam int unsigned DW   = 7;
  localparam int unsigned NDIG = 8;
  localparam int unsigned AW   = DW * NDIG;
  localparam int unsigned XW   = 60;
  localparam int unsigned RW   = AW + DW;
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned IW   = 4;
  localparam int unsigned SH   = DW * DIGITS_PER_CYCLE;

  localparam logic [DW-1:0] K        = DW'(113);
  localparam logic [IW-1:0] IDX_STEP = IW'(DIGITS_PER_CYCLE);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - DIGITS_PER_CYCLE);

  if (DIGITS_PER_CYCLE != 1 && DIGITS_PER_CYCLE != 2 &&
      DIGITS_PER_CYCLE != 4 && DIGITS_PER_CYCLE != 8) begin : g_bad_param
    $error("mul_113_recon: DIGITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        state, state_n;
  logic [AW-1:0] q_sh, q_sh_n;
  logic [AW-1:0] acc, acc_n;
  logic [DW-1:0] carry, carry_n;
  logic [IW-1:0] idx, idx_n;
  logic          in_ready_n, out_valid_n, ovf_n;
  logic [XW-1:0] x_n;

  logic [PW-1:0] p;
  logic [DW-1:0] c;
  logic [DW-1:0] chain_carry;
  logic [AW-1:0] digs;
  logic [AW-1:0] acc_shift;
  logic [RW-1:0] result;

  // DIGITS_PER_CYCLE digit multiply-adds chained combinationally; carry never exceeds 113
  always_comb begin : step_chain
    p    = '0;
    c    = carry;
    digs = '0;
    for (int j = 0; j < int'(DIGITS_PER_CYCLE); j++) begin
      p = PW'(q_sh[DW*j +: DW]) * PW'(K) + PW'(c);
      digs[DW*j +: DW] = p[DW-1:0];
      c = p[PW-1:DW];
    end
    chain_carry = c;
    acc_shift   = (acc >> SH) | (digs << (AW - SH));
    result      = {chain_carry, acc_shift};
  end

`ifdef MUL_113_RECON_REM_CHECK_EN
  logic err_pend, err_pend_n, err_n;
`endif

  always_comb begin : next_state
    state_n     = state;
    q_sh_n      = q_sh;
    acc_n       = acc;
    carry_n     = carry;
    idx_n       = idx;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    x_n         = X;
    ovf_n       = ovf;
`ifdef MUL_113_RECON_REM_CHECK_EN
    err_pend_n  = err_pend;
    err_n       = err;
`endif
    case (state)
      S_IDLE: begin
        in_ready_n = 1'b1;
        if (in_valid && in_ready) begin
          q_sh_n     = AW'(Q);
          carry_n    = R;
          acc_n      = '0;
          idx_n      = '0;
          in_ready_n = 1'b0;
          state_n    = S_CALC;
`ifdef MUL_113_RECON_REM_CHECK_EN
          err_pend_n = (R >= K);
`endif
        end
      end
      S_CALC: begin
        q_sh_n  = q_sh >> SH;
        acc_n   = acc_shift;
        carry_n = chain_carry;
        idx_n   = idx + IDX_STEP;
        if (idx == IDX_LAST) begin
          state_n     = S_DONE;
          out_valid_n = 1'b1;
          x_n         = result[XW-1:0];
          ovf_n       = |result[RW-1:XW];
`ifdef MUL_113_RECON_REM_CHECK_EN
          err_n       = err_pend;
`endif
        end
      end
      S_DONE: begin
        // results stay frozen until the consumer takes them
        if (out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = S_IDLE;
        end
      end
      default: begin
        state_n    = S_IDLE;
        in_ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      state     <= S_IDLE;
      q_sh      <= '0;
      acc       <= '0;
      carry     <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      X         <= '0;
      ovf       <= 1'b0;
`ifdef MUL_113_RECON_REM_CHECK_EN
      err_pend  <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      q_sh      <= q_sh_n;
      acc       <= acc_n;
      carry     <= carry_n;
      idx       <= idx_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      X         <= x_n;
      ovf       <= ovf_n;
`ifdef MUL_113_RECON_REM_CHECK_EN
      err_pend  <= err_pend_n;
      err       <= err_n;
`endif
    end
  end

`ifndef MUL_113_RECON_REM_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_113_recon.sv
// Scoreboard bench for mul_113_recon: directed corners, backpressure, mid-op reset, random round-trips.
module tb_mul_113_recon;

  localparam int unsigned DPC = 1;
`ifdef MUL_113_RECON_REM_CHECK_EN
  localparam bit REM_CHK = 1'b1;
`else
  localparam bit REM_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [59:0] x;
    logic        ovf;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [53:0] q = '0;
  logic [6:0]  r = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [59:0] x;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  mul_113_recon #(.DIGITS_PER_CYCLE(DPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Q(q), .R(r), .out_valid(out_valid), .out_ready(out_ready),
    .X(x), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [53:0] qq, input logic [6:0] rr);
    logic [63:0] t;
    exp_t e;
    t     = 64'(qq) * 64'd113 + 64'(rr);
    e.x   = t[59:0];
    e.ovf = |t[62:60];
    e.err = REM_CHK && (rr >= 7'd113);
    return e;
  endfunction

  // drive a pair, wait for acceptance, push the expected result at the handshake
  task automatic send(input logic [53:0] qq, input logic [6:0] rr, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    q = qq; r = rr; in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("send_timeout", 64'(n), 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // scoreboard monitor: compares every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_x", 64'(x), 64'(e.x));
        chk("out_ovf", 64'(ovf), 64'(e.ovf));
        chk("out_err", 64'(err), 64'(e.err));
      end
    end
  end

  initial begin
    int lat;
    logic [59:0] xh;
    logic [63:0] dvd;
    exp_t e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    // latency and basic value
    e = '{x: 60'd113, ovf: 1'b0, err: 1'b0};
    send(54'd1, 7'd0, e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("calc_in_ready", 64'(in_ready), 64'd0);
    end while (!out_valid && lat < 50);
    chk("latency", 64'(lat), 64'(8 / DPC + 1));
    drain();

    // directed corners
    send(54'd0, 7'd112, model(54'd0, 7'd112));
    send(54'd0, 7'd0, '{x: 60'd0, ovf: 1'b0, err: 1'b0});
    dvd = 64'h0FFF_FFFF_FFFF_FFF0;
    send(54'(dvd / 64'd113), 7'd15, model(54'(dvd / 64'd113), 7'd15));
    send({54{1'b1}}, 7'd0, '{x: 60'(64'h003F_FFFF_FFFF_FFFF * 64'd113), ovf: 1'b1, err: 1'b0});
    send(54'd0, 7'd127, '{x: 60'd127, ovf: 1'b0, err: REM_CHK});
    drain();

    // random dividends round-trip: expected X is the original dividend
    for (int i = 0; i < 200; i++) begin
      dvd = {$urandom, $urandom} & 64'h0FFF_FFFF_FFFF_FFFF;
      e = '{x: dvd[59:0], ovf: 1'b0, err: 1'b0};
      send(54'(dvd / 64'd113), 7'(dvd % 64'd113), e);
    end
    drain();

    // backpressure: result held, second pair not accepted until after output handshake
    out_ready = 1'b0;
    send(54'd5, 7'd3, '{x: 60'd568, ovf: 1'b0, err: 1'b0});
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    xh = x;
    chk("bp_x_first", 64'(xh), 64'd568);
    q = 54'd7; r = 7'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_x_hold", 64'(x), 64'(xh));
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp_after_valid", 64'(out_valid), 64'd0);
    chk("bp_after_in_ready", 64'(in_ready), 64'd1);
    sb.push_back('{x: 60'd791, ovf: 1'b0, err: 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // synchronous reset in the middle of CALC
    send({54{1'b1}}, 7'd99, model({54{1'b1}}, 7'd99));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    send(54'd2, 7'd5, '{x: 60'd231, ovf: 1'b0, err: 1'b0});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_113_recon.md
Name: mul_113_recon

Overview:
- Sequential inverse of the constant-113 divider: reconstructs X = Q*113 + R from a 54-bit quotient and 7-bit remainder.
- Used as an on-chip self-check / round-trip path beside the divider datapath. Results are compared against the original dividend.
- Processes Q in 7-bit digits (radix 128, since 113 < 128) with a carry chain, DIGITS_PER_CYCLE digits per clock.
- Uses a valid/ready handshake on both input and output.

Parameters:
- DIGITS_PER_CYCLE, 1, radix-128 digits of Q processed per CALC cycle. Legal values are 1, 2, 4, 8; any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  Q/R presented.
- in_ready  output  1  block can accept a new operand pair.
- Q  input  54  quotient.
- R  input  7  remainder.
- out_valid  output  1  result X/flags valid.
- out_ready  input  1  consumer accepts result.
- X  output  60  low 60 bits of Q*113+R.
- ovf  output  1  true result >= 2^60.
- err  output  1  R >= 113 (only with REM_CHECK_EN, else constant 0).

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, X=0, ovf=0, err=0, internal carry/digit counter/accumulator=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch Q zero-extended to 56 bits (8 digits d0..d7, d0 = Q[6:0]).
  - Load carry = R and digit index = 0.
  - Go to CALC.
- CALC, per digit step i:
  - p = d_i*113 + carry, 14 bits.
  - Accumulator bits [7i+6:7i] = p[6:0]; carry = p[13:7].
  - Invariant: carry <= 113 always (max p = 127*113+113 = 14464), so 7 bits suffice.
  - DIGITS_PER_CYCLE steps are chained combinationally per clock.
  - After digit 7: accumulator bits [62:56] = final carry, forming a 63-bit result. Go to DONE.
- DONE:
  - out_valid=1. X = result[59:0]. ovf = |result[62:60].
  - X/ovf/err are held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid drops next cycle and FSM goes to IDLE.
  - No same-cycle bypass: in_ready rises the cycle after the output handshake.
- Latency: input handshake at cycle 0 -> out_valid at cycle 8/DIGITS_PER_CYCLE + 1. With default 1, that is cycle 9.
- Throughput: one result per 8/DIGITS_PER_CYCLE + 2 cycles, with out_ready held high.
- in_ready=0 in CALC and DONE. Q/R changes outside the IDLE handshake are ignored.
- in_valid with no handshake: no state change.
- Reset mid-CALC or mid-DONE: operation discarded, out_valid=0 on the next cycle, FSM returns to IDLE.
- Q=0, R=0 -> X=0, flags 0. Still full latency, no early exit.
- Arithmetic is exact modulo 2^63. ovf is the only indication of truncation.

Optional Feature:
- Macro: MUL_113_RECON_REM_CHECK_EN.
- Defined:
  - err is latched at input handshake as (R >= 113) and presented with the result in DONE.
  - The computation still proceeds using the raw R.
- Undefined:
  - err is tied 0 and there is no comparator.
  - R in 113..127 is simply added.

Test Plan:
- Q=1, R=0, out_ready=1 -> X=113, ovf=0, err=0; out_valid at cycle 9 (DIGITS_PER_CYCLE=1), at cycle 2 (DIGITS_PER_CYCLE=8).
- Q=0, R=112 -> X=112; then Q=(2^60-16)/113, R=15 -> X=0xFFF_FFFF_FFFF_FFFF, ovf=0 (largest legal dividend round-trip).
- Q=2^54-1, R=0 -> ovf=1, X = (113*(2^54-1)) mod 2^60. Random 10k dividends: div_60_113 output fed in must reproduce the dividend exactly with ovf=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> X/ovf/err stable, in_ready=0; second in_valid is not accepted until the cycle after out_ready=1.
- rst_n=0 asserted at CALC digit 3 -> next cycle out_valid=0, in_ready=1. A new pair (Q=2, R=5) then yields X=231 with no residue from the aborted operation.
- With MUL_113_RECON_REM_CHECK_EN: Q=0, R=127 -> err=1, X=127. Without the macro, the same stimulus gives err=0, X=127.
